// File: rtl/nios2_irq_aggregator.sv
// nios2_irq_aggregator: merges peripheral interrupt lines into a single
// registered irq for the Nios II CPU. Each source has edge/level capture,
// a pending bit, a mask bit and a saturating rise counter, all visible
// through a small Avalon-MM register window with 1-cycle read latency.
//
// Word map: 0 PENDING (W1C, edge-mode bits only), 1 MASK, 2 EDGE_SEL,
// 3 CNT_SEL, 4 COUNT (any write clears the selected counter), 5 RAW,
// 6/7 reserved (read 0).
module nios2_irq_aggregator #(
  parameter int N_IRQ = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [15:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_CNT_SEL  = 3'd3;
  localparam logic [2:0] ADDR_COUNT    = 3'd4;
  localparam logic [2:0] ADDR_RAW      = 3'd5;

  logic [N_IRQ-1:0]            pending;
  logic [N_IRQ-1:0]            pending_nxt;
  logic [N_IRQ-1:0]            mask;
  logic [N_IRQ-1:0]            edge_sel;
  logic [3:0]                  cnt_sel;
  logic [N_IRQ-1:0]            prev_in;
  logic [N_IRQ-1:0]            rise;
  logic [N_IRQ-1:0][CNT_W-1:0] count;
  logic [N_IRQ-1:0][CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0]            cnt_rd;
  logic [15:0]                 rd_nxt;

  logic wr_en;
  logic wr_pending;
  logic wr_mask;
  logic wr_edge_sel;
  logic wr_cnt_sel;
  logic wr_count;

  // Writedata bits above the implemented register widths are ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Decode the write strobes for each register word.
  always_comb begin
    wr_en       = chipselect & ~write_n;
    wr_pending  = wr_en && (address == ADDR_PENDING);
    wr_mask     = wr_en && (address == ADDR_MASK);
    wr_edge_sel = wr_en && (address == ADDR_EDGE_SEL);
    wr_cnt_sel  = wr_en && (address == ADDR_CNT_SEL);
    wr_count    = wr_en && (address == ADDR_COUNT);
  end

  // Rising-edge detect against the previous-cycle sample.
  always_comb begin
    rise = irq_in & ~prev_in;
  end

  // Pending next state: edge mode holds/sets with W1C (a same-cycle rise
  // wins over the clear); level mode simply tracks the input.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_sel[i]) begin
        pending_nxt[i] = (pending[i] & ~(wr_pending & writedata[i])) | rise[i];
      end else begin
        pending_nxt[i] = irq_in[i];
      end
    end
  end

  // Counter next state: saturating increment on rise; a clear that lands
  // on a rise leaves the count at 1 so that event is not lost. Selects at
  // or above N_IRQ match no counter and therefore do nothing.
  always_comb begin
    count_nxt = count;
    for (int i = 0; i < N_IRQ; i++) begin
      if (wr_count && (cnt_sel == 4'(i))) begin
        count_nxt[i] = rise[i] ? CNT_W'(1) : '0;
      end else if (rise[i] && (count[i] != {CNT_W{1'b1}})) begin
        count_nxt[i] = count[i] + CNT_W'(1);
      end
    end
  end

  // Select the counter addressed by CNT_SEL for readback (0 when out of range).
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (cnt_sel == 4'(i)) begin
        cnt_rd = count[i];
      end
    end
  end

  // Read mux; uses pre-write register values so a same-cycle write shows
  // up one read later.
  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_PENDING:  rd_nxt[N_IRQ-1:0] = pending;
      ADDR_MASK:     rd_nxt[N_IRQ-1:0] = mask;
      ADDR_EDGE_SEL: rd_nxt[N_IRQ-1:0] = edge_sel;
      ADDR_CNT_SEL:  rd_nxt[3:0]       = cnt_sel;
      ADDR_COUNT:    rd_nxt[CNT_W-1:0] = cnt_rd;
      ADDR_RAW:      rd_nxt[N_IRQ-1:0] = irq_in;
      default:       rd_nxt = '0;
    endcase
  end

  // All architectural state, read data and the merged irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '1;
      cnt_sel  <= '0;
      prev_in  <= '0;
      count    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      prev_in  <= irq_in;
      count    <= count_nxt;
      readdata <= rd_nxt;
      irq      <= |(pending & mask);
      if (wr_mask) begin
        mask <= writedata[N_IRQ-1:0];
      end
      if (wr_edge_sel) begin
        edge_sel <= writedata[N_IRQ-1:0];
      end
      if (wr_cnt_sel) begin
        cnt_sel <= writedata[3:0];
      end
    end
  end

endmodule

// File: tb/tb_nios2_irq_aggregator.sv
// Directed bench for nios2_irq_aggregator (N_IRQ=4, CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_nios2_irq_aggregator;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [3:0]  irq_in;
  logic [15:0] readdata;
  logic        irq;

  int total;
  int bad;

  nios2_irq_aggregator #(.N_IRQ(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_tab [8];
    exp_tab = '{16'h0000, 16'h0000, 16'h000F, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d);
      total++;
      if (d !== exp_tab[a]) begin
        bad++; $display("FAIL reset_read[%0d]: got %h want %h", a, d, exp_tab[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_write(3'd1, 16'h0005);
    total++;
    if (readdata !== 16'h0000) begin
      bad++; $display("FAIL b2b_prewrite: got %h want 0000", readdata);
    end
    do_read(3'd1, d);
    total++;
    if (d !== 16'h0005) begin
      bad++; $display("FAIL b2b_postwrite: got %h want 0005", d);
    end
    do_write(3'd1, 16'h0000);
  endtask

  task automatic test_edge_pulse();
    logic [15:0] d;
    do_write(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    @(posedge clk); #1;
    irq_in[0] = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL edge_irq_early: got %b want 0", irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL edge_irq_set: got %b want 1", irq);
    end
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL edge_pending: got %h want 0001", d);
    end
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL edge_count: got %h want 0001", d);
    end
    do_write(3'd0, 16'h0001);
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL w1c_irq_hold: got %b want 1", irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL w1c_irq_clear: got %b want 0", irq);
    end
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL w1c_pending: got %h want 0000", d);
    end
  endtask

  task automatic test_level_hold();
    logic [15:0] d;
    logic        seen;
    irq_in[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    irq_in[1] = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL hold_irq_masked: got %b want 0", irq);
    end
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0002) begin
      bad++; $display("FAIL hold_pending: got %h want 0002", d);
    end
    do_write(3'd3, 16'h0001);
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL hold_count: got %h want 0001", d);
    end
    do_write(3'd1, 16'h0002);
    seen = irq;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(posedge clk); #1;
      seen = irq;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++; $display("FAIL hold_unmask_irq: got %b want 1 within 2 cycles", seen);
    end
    do_write(3'd0, 16'h0002);
    do_write(3'd1, 16'h0000);
  endtask

  task automatic test_level_mode();
    logic [15:0] d;
    do_write(3'd2, 16'h0000);
    do_write(3'd1, 16'h0004);
    chipselect = 1'b1; write_n = 1'b1; address = 3'd0;
    irq_in[2] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (readdata !== 16'h0000) begin
      bad++; $display("FAIL level_delay0: got %h want 0000", readdata);
    end
    @(posedge clk); #1;
    chipselect = 1'b0;
    total++;
    if (readdata !== 16'h0004) begin
      bad++; $display("FAIL level_follow: got %h want 0004", readdata);
    end
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL level_irq: got %b want 1", irq);
    end
    do_write(3'd0, 16'h0004);
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL level_w1c_ignored: got %h want 0004", d);
    end
    do_write(3'd2, 16'h000F);
    irq_in[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0004) begin
      bad++; $display("FAIL to_edge_keep: got %h want 0004", d);
    end
    do_write(3'd0, 16'h0004);
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL to_edge_w1c: got %h want 0000", d);
    end
    do_write(3'd1, 16'h0000);
  endtask

  task automatic test_collide();
    logic [15:0] d;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 16'h0001;
    irq_in[0] = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; irq_in[0] = 1'b0;
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL collide_pending: got %h want 0001", d);
    end
    do_write(3'd3, 16'h0000);
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0002) begin
      bad++; $display("FAIL collide_count_pre: got %h want 0002", d);
    end
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 16'h0000;
    irq_in[0] = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; irq_in[0] = 1'b0;
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0001) begin
      bad++; $display("FAIL collide_count_clr: got %h want 0001", d);
    end
    do_write(3'd0, 16'h000F);
  endtask

  task automatic test_raw();
    logic [15:0] d;
    irq_in = 4'b1010;
    do_read(3'd5, d);
    total++;
    if (d !== 16'h000A) begin
      bad++; $display("FAIL raw_read: got %h want 000a", d);
    end
    irq_in = 4'b0000;
    do_write(3'd0, 16'h000F);
    do_write(3'd6, 16'hFFFF);
    do_read(3'd6, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL reserved6: got %h want 0000", d);
    end
    do_write(3'd3, 16'h0009);
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL cnt_sel_oor: got %h want 0000", d);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] d;
    do_write(3'd3, 16'h0003);
    do_write(3'd1, 16'h0008);
    for (int p = 0; p < 20; p++) begin
      irq_in[3] = 1'b1;
      @(posedge clk); #1;
      irq_in[3] = 1'b0;
      @(posedge clk); #1;
    end
    do_read(3'd4, d);
    total++;
    if (d !== 16'h000F) begin
      bad++; $display("FAIL sat_count: got %h want 000f", d);
    end
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL sat_irq: got %b want 1", irq);
    end
    chipselect = 1'b1; address = 3'd4;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL async_rst_irq: got %b want 0", irq);
    end
    total++;
    if (readdata !== 16'h0000) begin
      bad++; $display("FAIL async_rst_readdata: got %h want 0000", readdata);
    end
    chipselect = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_write(3'd3, 16'h0003);
    do_read(3'd4, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL rst_count: got %h want 0000", d);
    end
    do_read(3'd1, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL rst_mask: got %h want 0000", d);
    end
    do_read(3'd0, d);
    total++;
    if (d !== 16'h0000) begin
      bad++; $display("FAIL rst_pending: got %h want 0000", d);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    chipselect = 1'b0;
    address = '0;
    write_n = 1'b1;
    writedata = '0;
    irq_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_edge_pulse();
    test_level_hold();
    test_level_mode();
    test_collide();
    test_raw();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
